// File: rtl/dac_serial_tx.sv
`default_nettype none
// ============================================================================
// Module   : dac_serial_tx
// Purpose  : Serial DAC transmitter. Takes samples on a valid/ready handshake,
//            frames each one as {pd_mode, sample, zero pad} and shifts it out
//            MSB-first on a divided serial clock, framed by active-low sync.
//            Optionally drops a sample identical to the last one sent.
// Ports    : clk, rst          - system clock, async active-high reset
//            sample, pd_mode   - sample word and DAC power-down bits
//            sample_valid      - sample/pd_mode valid this cycle
//            sample_ready      - block accepts this cycle (IDLE only)
//            busy              - frame in progress (SHIFT or GAP)
//            frame_done        - one-cycle pulse after the last bit
//            sync, sclk, din   - DAC serial interface (sync active low)
// Revision : 1.0 - initial release
// ============================================================================
module dac_serial_tx #(
  parameter int DATA_W      = 8,
  parameter int FRAME_W     = 16,
  parameter int CLK_DIV     = 4,
  parameter int SYNC_GAP    = 2,
  parameter int SKIP_REPEAT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] sample,
  input  logic [1:0]        pd_mode,
  input  logic              sample_valid,
  output logic              sample_ready,
  output logic              busy,
  output logic              frame_done,
  output logic              sync,
  output logic              sclk,
  output logic              din
);

  localparam int c_DIV_W = $clog2(CLK_DIV + 1);
  localparam int c_BIT_W = $clog2(FRAME_W + 1);
  localparam int c_GAP_W = $clog2(SYNC_GAP + 1);
  localparam int c_KEY_W = DATA_W + 2;

  localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);
  localparam logic [c_BIT_W-1:0] c_BIT_LAST = c_BIT_W'(FRAME_W - 1);
  localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'(SYNC_GAP - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t               r_state;
  logic [FRAME_W-1:0]   r_shift;
  logic [c_KEY_W-1:0]   r_key;
  logic [c_KEY_W-1:0]   r_last;
  logic                 r_last_vld;
  logic [c_DIV_W-1:0]   r_div;
  logic [c_BIT_W-1:0]   r_bit;
  logic [c_GAP_W-1:0]   r_gap;
  logic                 r_ready;
  logic                 r_done;
  logic                 r_sync;
  logic                 r_sclk;
  logic                 r_din;

  logic [c_KEY_W-1:0]   w_key;
  logic [FRAME_W-1:0]   w_frame;
  logic                 w_accept;
  logic                 w_skip;

  assign w_key    = {pd_mode, sample};
  // Left-justify the key; the low FRAME_W-DATA_W-2 bits are zero padding.
  assign w_frame  = FRAME_W'(w_key) << (FRAME_W - c_KEY_W);
  // r_ready is only ever high in IDLE, so it doubles as the state qualifier.
  assign w_accept = sample_valid && r_ready;
  assign w_skip   = (SKIP_REPEAT != 0) && r_last_vld && (w_key == r_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_key      <= '0;
      r_last     <= '0;
      r_last_vld <= 1'b0;
      r_div      <= '0;
      r_bit      <= '0;
      r_gap      <= '0;
      r_ready    <= 1'b0;
      r_done     <= 1'b0;
      r_sync     <= 1'b1;
      r_sclk     <= 1'b1;
      r_din      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_ready <= 1'b1;
          // A skipped repeat is consumed here and leaves the FSM in IDLE.
          if (w_accept && !w_skip) begin
            r_state <= SHIFT;
            r_ready <= 1'b0;
            r_sync  <= 1'b0;
            r_sclk  <= 1'b1;
            r_din   <= w_frame[FRAME_W-1];
            r_shift <= {w_frame[FRAME_W-2:0], 1'b0};
            r_key   <= w_key;
            r_div   <= '0;
            r_bit   <= '0;
          end
        end

        SHIFT: begin
          if (r_div == c_DIV_LAST) begin
            r_div <= '0;
            if (r_sclk) begin
              // End of high half: falling edge, DAC samples din here.
              r_sclk <= 1'b0;
            end else if (r_bit == c_BIT_LAST) begin
              r_state    <= GAP;
              r_sync     <= 1'b1;
              r_sclk     <= 1'b1;
              r_din      <= 1'b0;
              r_done     <= 1'b1;
              r_gap      <= '0;
              r_bit      <= '0;
              r_last     <= r_key;
              r_last_vld <= 1'b1;
            end else begin
              // Start of the next bit period: din moves only while sclk is high.
              r_sclk  <= 1'b1;
              r_din   <= r_shift[FRAME_W-1];
              r_shift <= {r_shift[FRAME_W-2:0], 1'b0};
              r_bit   <= r_bit + 1'b1;
            end
          end else begin
            r_div <= r_div + 1'b1;
          end
        end

        GAP: begin
          if (r_gap == c_GAP_LAST) begin
            r_state <= IDLE;
            r_ready <= 1'b1;
            r_gap   <= '0;
          end else begin
            r_gap <= r_gap + 1'b1;
          end
        end

        default: begin
          r_state <= IDLE;
          r_sync  <= 1'b1;
          r_sclk  <= 1'b1;
          r_din   <= 1'b0;
        end
      endcase
    end
  end

  assign sample_ready = r_ready;
  assign busy         = (r_state != IDLE);
  assign frame_done   = r_done;
  assign sync         = r_sync;
  assign sclk         = r_sclk;
  assign din          = r_din;

endmodule
`default_nettype wire

// File: tb/tb_dac_serial_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_dac_serial_tx
// Purpose  : Self-checking bench for dac_serial_tx. Two instances share the
//            stimulus: dut0 (SKIP_REPEAT=0) and dut1 (SKIP_REPEAT=1); a select
//            bit routes one of them to a common monitor. Expected frame words
//            are queued at accept and compared when the frame ends.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dac_serial_tx;

  localparam int DW      = 8;
  localparam int FW      = 16;
  localparam int CD      = 2;
  localparam int SG      = 2;
  localparam int SPACING = FW * 2 * CD + SG + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] sample = '0;
  logic [1:0]    pd_mode = 2'b00;
  logic          sample_valid = 1'b0;

  logic ready0, busy0, done0, sync0, sclk0, din0;
  logic ready1, busy1, done1, sync1, sclk1, din1;

  always #5 clk = ~clk;

  dac_serial_tx #(.DATA_W(DW), .FRAME_W(FW), .CLK_DIV(CD), .SYNC_GAP(SG), .SKIP_REPEAT(0)) dut0 (
    .clk(clk), .rst(rst), .sample(sample), .pd_mode(pd_mode), .sample_valid(sample_valid),
    .sample_ready(ready0), .busy(busy0), .frame_done(done0), .sync(sync0), .sclk(sclk0), .din(din0)
  );

  dac_serial_tx #(.DATA_W(DW), .FRAME_W(FW), .CLK_DIV(CD), .SYNC_GAP(SG), .SKIP_REPEAT(1)) dut1 (
    .clk(clk), .rst(rst), .sample(sample), .pd_mode(pd_mode), .sample_valid(sample_valid),
    .sample_ready(ready1), .busy(busy1), .frame_done(done1), .sync(sync1), .sclk(sclk1), .din(din1)
  );

  logic sel = 1'b0;
  logic w_ready, w_busy, w_done, w_sync, w_sclk, w_din;
  assign w_ready = sel ? ready1 : ready0;
  assign w_busy  = sel ? busy1  : busy0;
  assign w_done  = sel ? done1  : done0;
  assign w_sync  = sel ? sync1  : sync0;
  assign w_sclk  = sel ? sclk1  : sclk0;
  assign w_din   = sel ? din1   : din0;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- monitor / scoreboard ----------------
  logic [15:0] exp_q[$];
  logic [15:0] word = '0;
  int          nbits = 0, nlow = 0, ndone = 0, rise_cyc = 0;
  logic        p_sync = 1'b1, p_sclk = 1'b1, p_din = 1'b0;
  logic [9:0]  m_last = '0;
  logic        m_last_vld = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      word = '0; nbits = 0; nlow = 0;
      p_sync = 1'b1; p_sclk = 1'b1; p_din = 1'b0;
      m_last_vld = 1'b0;
    end else begin
      if (sample_valid && w_ready) begin
        if (!(sel && m_last_vld && ({pd_mode, sample} == m_last))) begin
          exp_q.push_back(16'({pd_mode, sample}) << (FW - DW - 2));
          m_last = {pd_mode, sample};
          m_last_vld = 1'b1;
        end
      end
      if (w_done) ndone++;
      if (!w_sync) nlow++;
      if (p_sclk && !w_sclk && !w_sync) begin
        check("din_stable_at_fall", w_din, p_din);
        word = {word[14:0], w_din};
        nbits++;
      end
      if (!p_sync && w_sync) begin
        check("frame_done_at_end", w_done, 1'b1);
        check("sync_low_cycles", nlow, FW * 2 * CD);
        check("falling_edges", nbits, FW);
        if (exp_q.size() > 0) check("frame_word", word, exp_q.pop_front());
        else check("frame_expected", exp_q.size(), 1);
        word = '0; nbits = 0; nlow = 0;
        rise_cyc = cyc;
      end
      p_sync = w_sync; p_sclk = w_sclk; p_din = w_din;
    end
  end

  // ---------------- stimulus helpers ----------------
  // Present one sample; returns the index of the accept cycle.
  task automatic send(input logic [DW-1:0] s, input logic [1:0] p, output int acc);
    int t = 0;
    @(posedge clk); #1;
    sample = s; pd_mode = p; sample_valid = 1'b1;
    while (!w_ready && t < 1000) begin @(posedge clk); #1; t++; end
    if (!w_ready) check("ready_timeout", w_ready, 1'b1);
    acc = cyc;
    @(posedge clk); #1;
    sample_valid = 1'b0;
  endtask

  task automatic wait_ready(output int rc);
    int t = 0;
    while (!w_ready && t < 1000) begin @(posedge clk); #1; t++; end
    if (!w_ready) check("ready_return_timeout", w_ready, 1'b1);
    rc = cyc;
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((w_busy || exp_q.size() != 0) && t < 2000) begin @(posedge clk); #1; t++; end
    if (w_busy) check("idle_timeout", w_busy, 1'b0);
    check("queue_drained", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, rc, n0, t, lowcnt;
    int accs[3];

    // Reset defaults
    repeat (2) @(negedge clk);
    check("rst_sync", w_sync, 1'b1);
    check("rst_sclk", w_sclk, 1'b1);
    check("rst_din", w_din, 1'b0);
    check("rst_busy", w_busy, 1'b0);
    check("rst_ready", w_ready, 1'b0);
    check("rst_done", w_done, 1'b0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    check("ready_after_release", w_ready, 1'b1);

    // Single frame 0xA5/00 -> 0x2940
    n0 = ndone;
    send(8'hA5, 2'b00, acc);
    check("busy_in_frame", w_busy, 1'b1);
    check("ready_in_frame", w_ready, 1'b0);
    wait_ready(rc);
    check("ready_return_cycles", rc - acc, SPACING);
    wait_idle();
    check("single_done_pulses", ndone - n0, 1);

    // Power-down frame 0x00/11 -> 0xC000
    send(8'h00, 2'b11, acc);
    wait_idle();

    // Back-to-back with valid held high
    @(posedge clk); #1;
    sample_valid = 1'b1; pd_mode = 2'b00;
    for (int i = 0; i < 3; i++) begin
      sample = DW'(i + 1);
      t = 0;
      while (!w_ready && t < 1000) begin @(posedge clk); #1; t++; end
      if (!w_ready) check("b2b_ready_timeout", w_ready, 1'b1);
      accs[i] = cyc;
      if (i > 0) begin
        check("b2b_spacing", accs[i] - accs[i-1], SPACING);
        check("b2b_sync_high_gap", accs[i] - rise_cyc, SG);
      end
      @(posedge clk); #1;
    end
    sample_valid = 1'b0;
    wait_idle();

    // Mid-frame reset during 0xFF/00
    send(8'hFF, 2'b00, acc);
    t = 0;
    while (nbits < 5 && t < 1000) begin @(negedge clk); t++; end
    check("reached_5_edges", nbits, 5);
    n0 = ndone;
    #2 rst = 1'b1;
    #1;
    check("async_rst_sync", w_sync, 1'b1);
    check("async_rst_sclk", w_sclk, 1'b1);
    check("async_rst_busy", w_busy, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk); #1;
    check("no_done_after_abort", ndone - n0, 0);
    send(8'h10, 2'b00, acc);
    wait_idle();

    // Repeat suppression on dut1
    do_reset();
    sel = 1'b1;
    send(8'h33, 2'b00, acc);
    wait_idle();
    n0 = ndone;
    send(8'h33, 2'b00, acc);
    check("skip_ready_kept", w_ready, 1'b1);
    check("skip_not_busy", w_busy, 1'b0);
    lowcnt = 0;
    repeat (10) begin @(negedge clk); if (!w_sync) lowcnt++; end
    check("skip_sync_high", lowcnt, 0);
    check("skip_no_done", ndone - n0, 0);
    send(8'h33, 2'b01, acc);
    wait_idle();
    do_reset();
    n0 = ndone;
    send(8'h33, 2'b00, acc);
    wait_idle();
    check("resend_after_reset", ndone - n0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
